// File: rtl/clkdiv_pkg.sv
// Shared constants, config record and high-phase helper for the programmable
// clock divider.
package clkdiv_pkg;

  localparam int DIV_WIDTH_DEF   = 16;
  localparam int DEFAULT_DIV_DEF = 2;
  localparam int MIN_DIV         = 2;

  typedef struct packed {
    logic [DIV_WIDTH_DEF-1:0] div;
    logic                     en;
  } clkdiv_cfg_t;

  // Number of high cycles in a period of d; odd divisors get the extra high cycle.
  function automatic logic [31:0] high_count(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, single-entry pending update slot and
// registered clk_out/tick outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 wr_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_en_i,
  input  logic                 sync_i,
  output logic                 pend_o,
  output logic                 clk_out_o,
  output logic                 tick_o
);

  localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] MIN_D = DIV_WIDTH'(MIN_DIV);
  localparam logic [DIV_WIDTH-1:0] RST_D = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] p_div_q, p_div_d;
  logic [DIV_WIDTH-1:0] wr_div;
  logic                 en_q, en_d;
  logic                 p_en_q, p_en_d;
  logic                 p_vld_q, p_vld_d;
  logic                 clk_out_q, clk_out_d;
  logic                 tick_q, tick_d;
  logic                 boundary;

  assign wr_div   = (cfg_div_i < MIN_D) ? MIN_D : cfg_div_i;
  // A disabled channel sits on a boundary every cycle, so writes land at once.
  assign boundary = !en_q || sync_i || (cnt_q == div_q - ONE);

  always_comb begin
    div_d   = div_q;
    en_d    = en_q;
    p_div_d = p_div_q;
    p_en_d  = p_en_q;
    p_vld_d = p_vld_q;
    cnt_d   = cnt_q + ONE;
    if (boundary) begin
      cnt_d   = '0;
      p_vld_d = 1'b0;
      if (wr_i) begin
        div_d = wr_div;
        en_d  = cfg_en_i;
      end else if (p_vld_q) begin
        div_d = p_div_q;
        en_d  = p_en_q;
      end
    end else if (wr_i) begin
      p_div_d = wr_div;
      p_en_d  = cfg_en_i;
      p_vld_d = 1'b1;
    end
    clk_out_d = en_d && (32'(cnt_d) < high_count(32'(div_d)));
    tick_d    = en_d && (cnt_d == '0);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= RST_D;
      en_q      <= 1'b0;
      cnt_q     <= '0;
      p_div_q   <= RST_D;
      p_en_q    <= 1'b0;
      p_vld_q   <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      p_div_q   <= p_div_d;
      p_en_q    <= p_en_d;
      p_vld_q   <= p_vld_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pend_o    = p_vld_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock divider: config decode, ready mux and sync
// fan-out around NUM_CH independent channels.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_WIDTH    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_WIDTH-1:0]  cfg_ch,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic                 cfg_en,
  input  logic                 sync,
  output logic [NUM_CH-1:0]    clk_out,
  output logic [NUM_CH-1:0]    tick
);

  // Handshake: a config word transfers on a rising edge where cfg_valid and
  // cfg_ready are both high; cfg_ready only depends on the addressed channel.
  logic [NUM_CH-1:0]          pend;
  logic [(1<<CH_WIDTH)-1:0]   pend_ext;
  logic                       accept;

  // Unused channel indices read as never-pending so they are accepted and dropped.
  always_comb begin
    pend_ext             = '0;
    pend_ext[NUM_CH-1:0] = pend;
  end

  assign cfg_ready = !pend_ext[cfg_ch];
  assign accept    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .wr_i      (accept && (cfg_ch == CH_WIDTH'(i))),
      .cfg_div_i (cfg_div),
      .cfg_en_i  (cfg_en),
      .sync_i    (sync),
      .pend_o    (pend[i]),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Bench for clock_divider_prog: period-start model checked every cycle plus
// directed scenarios with hand-derived waveforms.
module tb_clock_divider_prog;

  localparam int NUM_CH    = 4;
  localparam int DIV_WIDTH = 16;
  localparam int CH_WIDTH  = 2;
  localparam int W         = 2 * NUM_CH + 1;

  logic                 clk_in    = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_en    = 1'b0;
  logic                 sync      = 1'b0;
  logic [CH_WIDTH-1:0]  cfg_ch    = '0;
  logic [DIV_WIDTH-1:0] cfg_div   = '0;
  logic                 cfg_ready;
  logic [NUM_CH-1:0]    clk_out;
  logic [NUM_CH-1:0]    tick;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  clock_divider_prog #(
    .NUM_CH      (NUM_CH),
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .sync      (sync),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by the cycle its current period started; the
  // output at cycle t follows from t - start against the period rules.
  int m_div[NUM_CH], m_pdiv[NUM_CH], m_start[NUM_CH];
  bit m_en[NUM_CH], m_pen[NUM_CH], m_pend[NUM_CH];
  int cyc = 0;

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c]   = 2;
      m_en[c]    = 1'b0;
      m_pend[c]  = 1'b0;
      m_start[c] = cyc;
    end
  endtask

  task automatic model_step(input bit v, input int ch, input int d, input bit e, input bit s);
    bit acc;
    bit wr;
    bit new_period;
    cyc++;
    acc = v && ((ch >= NUM_CH) || !m_pend[ch]);
    for (int c = 0; c < NUM_CH; c++) begin
      wr         = acc && (ch == c);
      new_period = !m_en[c] || s || ((cyc - m_start[c]) >= m_div[c]);
      if (new_period) begin
        if (wr) begin
          m_div[c] = eff_div(d);
          m_en[c]  = e;
        end else if (m_pend[c]) begin
          m_div[c] = m_pdiv[c];
          m_en[c]  = m_pen[c];
        end
        m_pend[c]  = 1'b0;
        m_start[c] = cyc;
      end else if (wr) begin
        m_pdiv[c] = eff_div(d);
        m_pen[c]  = e;
        m_pend[c] = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(posedge clk_in) begin
    logic [NUM_CH-1:0] ec, et;
    logic              er;
    logic [W-1:0]      exp_v;
    int                pos;
    if (!rst_n) model_reset();
    else model_step(cfg_valid, int'(cfg_ch), int'(cfg_div), cfg_en, sync);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      pos   = cyc - m_start[c];
      ec[c] = m_en[c] && (pos < (m_div[c] + 1) / 2);
      et[c] = m_en[c] && (pos == 0);
    end
    er = (int'(cfg_ch) >= NUM_CH) || !m_pend[cfg_ch];
    exp_q.push_back({er, et, ec});
    exp_v = exp_q.pop_front();
    check("model clk_out", 32'(clk_out), 32'(exp_v[NUM_CH-1:0]));
    check("model tick", 32'(tick), 32'(exp_v[2*NUM_CH-1:NUM_CH]));
    check("model cfg_ready", 32'(cfg_ready), 32'(exp_v[W-1]));
  end

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic cfg_write(input int ch, input int d, input bit e, output int waited);
    cfg_valid = 1'b1;
    cfg_ch    = CH_WIDTH'(ch);
    cfg_div   = DIV_WIDTH'(d);
    cfg_en    = e;
    waited    = 0;
    while (!cfg_ready && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    if (!cfg_ready) timeout_fail("cfg_write handshake");
    else @(posedge clk_in);
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int ch);
    int n;
    n = 0;
    while (!tick[ch] && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (!tick[ch]) timeout_fail("wait_tick");
  endtask

  task automatic next_tick(input logic [NUM_CH-1:0] mask, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (((tick & mask) != mask) && n < 100);
    if ((tick & mask) != mask) timeout_fail("next_tick");
  endtask

  task automatic sample(input int ch, input int len,
                        output logic [15:0] c, output logic [15:0] t, output logic [15:0] r);
    c = '0;
    t = '0;
    r = '0;
    for (int i = 0; i < len; i++) begin
      c = {c[14:0], clk_out[ch]};
      t = {t[14:0], tick[ch]};
      r = {r[14:0], cfg_ready};
      @(negedge clk_in);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [15:0] sc, st, sr;
    int          w1, w2, n;

    // reset state
    idle(3);
    check("reset clk_out", 32'(clk_out), 32'h0);
    check("reset tick", 32'(tick), 32'h0);
    check("reset cfg_ready", 32'(cfg_ready), 32'h1);
    rst_n = 1'b1;
    idle(2);

    // ch0 D=4: first tick right after acceptance, 1100 repeating
    cfg_write(0, 4, 1'b1, w1);
    sample(0, 8, sc, st, sr);
    check("d4 clk_out pattern", 32'(sc), 32'b11001100);
    check("d4 tick pattern", 32'(st), 32'b10001000);

    // ch1 D=5: 3 high / 2 low
    cfg_write(1, 5, 1'b1, w1);
    sample(1, 10, sc, st, sr);
    check("d5 clk_out pattern", 32'(sc), 32'b1110011100);
    check("d5 tick pattern", 32'(st), 32'b1000010000);

    // D=1 and D=0 clamp to 2
    cfg_write(1, 1, 1'b1, w1);
    wait_tick(1);
    sample(1, 4, sc, st, sr);
    check("d1 clk_out pattern", 32'(sc), 32'b1010);
    check("d1 tick pattern", 32'(st), 32'b1010);
    cfg_write(1, 0, 1'b1, w1);
    wait_tick(1);
    sample(1, 4, sc, st, sr);
    check("d0 clk_out pattern", 32'(sc), 32'b1010);
    check("d0 tick pattern", 32'(st), 32'b1010);

    // ch0 4 -> 6 written at cnt=1: period finishes as 4, ready low until wrap
    wait_tick(0);
    idle(1);
    cfg_write(0, 6, 1'b1, w1);
    sample(0, 8, sc, st, sr);
    check("d4to6 clk_out", 32'(sc), 32'b00111000);
    check("d4to6 tick", 32'(st), 32'b00100000);
    check("d4to6 cfg_ready", 32'(sr), 32'b00111111);

    // second write while pending stalls until the boundary frees the slot
    wait_tick(0);
    cfg_write(0, 3, 1'b1, w1);
    check("first write no stall", 32'(w1), 32'd0);
    cfg_write(0, 8, 1'b1, w2);
    check("second write stall cycles", 32'(w2), 32'd5);
    wait_tick(0);
    next_tick(4'b0001, n);
    check("d8 tick spacing", 32'(n), 32'd8);

    // sync phase-aligns ch0 D=4 and ch1 D=6; repeated sync holds phase 0
    cfg_write(0, 4, 1'b1, w1);
    cfg_write(1, 6, 1'b1, w1);
    sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("sync tick phase0", 32'(tick[1:0]), 32'b11);
      check("sync clk_out phase0", 32'(clk_out[1:0]), 32'b11);
    end
    sync = 1'b0;
    next_tick(4'b0011, n);
    check("coincident tick spacing", 32'(n), 32'd12);

    // disabling ch1 mid-period lets the current period finish
    wait_tick(1);
    idle(1);
    cfg_write(1, 6, 1'b0, w1);
    sample(1, 6, sc, st, sr);
    check("disable tail clk_out", 32'(sc), 32'b100000);

    // async reset with an update pending on ch0
    wait_tick(0);
    cfg_write(0, 10, 1'b1, w1);
    check("pending before reset ready", 32'(cfg_ready), 32'h0);
    check("pending before reset clk_out0", 32'(clk_out[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset clk_out", 32'(clk_out), 32'h0);
    check("async reset tick", 32'(tick), 32'h0);
    check("async reset cfg_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk_in);
    rst_n = 1'b1;
    idle(10);
    check("post reset cfg_ready", 32'(cfg_ready), 32'h1);
    check("post reset clk_out", 32'(clk_out), 32'h0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

- Runtime-programmable, multi-channel integer clock divider for the NCO datapath.
- Each channel derives a divided clock-enable waveform plus a one-cycle period strobe from the single system clock.
- The divisor and enable are loaded per channel over a valid/ready config port and take effect glitch-free at the next period boundary.
- A global sync input phase-aligns all channels.

## Interface

- `NUM_CH`, 4: number of independent divider channels (≥1).
- `DIV_WIDTH`, 16: width of divisor; divisor = full output period in `clk_in` cycles.
- `DEFAULT_DIV`, 2: divisor loaded at reset (2 ≤ DEFAULT_DIV < 2^DIV_WIDTH).
- `CH_WIDTH`, max(1, clog2(NUM_CH)): channel index width (derived).

- `clk_in`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accepted when valid && ready.
- `cfg_ch`  in  CH_WIDTH  target channel; values ≥ NUM_CH are accepted and ignored.
- `cfg_div`  in  DIV_WIDTH  new divisor.
- `cfg_en`  in  1  new channel enable.
- `sync`  in  1  restart all enabled channels at phase 0.
- `clk_out`  out  NUM_CH  registered divided waveform per channel.
- `tick`  out  NUM_CH  one-cycle strobe at start of each period per channel.

## Operation

**Per-channel state**
- `div` (DIV_WIDTH), `en`, `cnt` (DIV_WIDTH, runs 0..div-1).
- Pending slot: `p_div`, `p_en`, `p_vld`.

**Divisor rules**
- Effective divisor D = max(cfg_div, 2); 0 and 1 clamp to 2.
- High count H = (D+1)>>1, so odd D gives ceil(D/2) high and floor(D/2) low.

**Outputs**
- Registered: `clk_out[i]` = en && cnt_next < H.
- `tick[i]` = en && cnt_next == 0.
- `tick` coincides with the first high cycle of `clk_out`.

**Boundary**
- A channel is at a boundary when `cnt == div-1`, or when it is disabled.
- At a boundary `cnt` wraps to 0.
- If an update is pending, (div, en) ← pending and `p_vld` clears.
- Nothing applies mid-period.

**Config acceptance**
- `cfg_ready` = !p_vld[cfg_ch], combinational on `cfg_ch`; it is 1 for out-of-range `cfg_ch`.
- An accepted write at a boundary cycle of the target applies on that same edge and bypasses the pending slot.
- Otherwise it is stored pending.
- Disabled channel: a write applies on the acceptance edge.
- Disabling (`cfg_en=0`) also waits for the boundary. `clk_out` is never truncated mid-period.

**Disabled channel**
- `cnt` = 0, `clk_out` = 0, `tick` = 0.

**sync**
- Every channel is treated as at a boundary: pending (or same-cycle accepted) updates apply, `cnt` ← 0.
- Enabled channels output `clk_out` = 1 and `tick` = 1 on the next cycle.
- A sync in consecutive cycles holds phase 0.

**Reset (async, any time)**
- div = DEFAULT_DIV, en = 0, cnt = 0, p_vld = 0.
- `clk_out` = 0, `tick` = 0, `cfg_ready` = 1.
- Mid-operation reset drops pending updates; outputs go low immediately.

## Timing

- Enable latency: write accepted at edge k on a disabled channel → `clk_out` = 1 and `tick` = 1 visible after edge k.
- Period = D cycles exactly.
- Tick spacing = D, with no jitter across divisor changes.
- Update latency on an enabled channel: 0 to D-1 cycles after acceptance, always landing on the wrap edge.
- `cfg_ready` deasserts the cycle after a write is stored pending; it reasserts the cycle after the boundary consumes it.
- Simultaneous acceptance, boundary and sync on one channel: single apply, no pending left.

## Structure

**Shared package `clkdiv_pkg`**
- DIV_WIDTH default, DEFAULT_DIV and the clamp constant (MIN_DIV = 2).
- Typedef `clkdiv_cfg_t` {div, en}.
- Helper function for the H computation.

**Sub-module `clkdiv_channel`**
- Counter, pending slot, output registers; instantiated NUM_CH times in a generate loop.
- Top level holds only cfg decode, `cfg_ready` mux and `sync` fan-out.

## Test plan

1. Reset, write ch0 D=4 en=1 → ch0 `clk_out` 1100 repeating, `tick` every 4 cycles, first `tick` the cycle after acceptance.
2. ch1 D=5 → 3 high / 2 low, period 5; D=1 and D=0 writes → behave as D=2 (10 repeating).
3. ch0 running D=4, write D=6 at cnt=1 → current period completes as 4 cycles, next period 6 cycles; `cfg_ready` low for cfg_ch=0 until the wrap edge.
4. While ch0 is pending, assert second write → stalls (`cfg_ready`=0) and is applied one period later; no period shorter than min(old, new).
5. ch0 D=4, ch1 D=6 free-running, pulse `sync` → both `tick` on the next cycle, then ticks coincide every 12 cycles.
6. Assert `rst_n`=0 mid-period with a pending update → all outputs 0 asynchronously; after release, channels disabled and `div` = DEFAULT_DIV, pending discarded.
